// File: rtl/act_stream_unit.sv
// Two-stage streaming fixed-point activation engine (LReLU, sigmoid-3/5 segment, tanh-5 segment).
// Optional saturation counter on the sat_count port, built only when ACT_SAT_COUNT_EN is defined.
module act_stream_unit #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int LANES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_mode,
  input  logic [WIDTH-1:0]         in_alpha,
  input  logic [LANES*WIDTH-1:0]   in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*WIDTH-1:0]   out_data
`ifdef ACT_SAT_COUNT_EN
  ,
  output logic [31:0]              sat_count
`endif
);

  localparam int XW = 2 * WIDTH;
  typedef logic signed [XW-1:0] wide_t;

  localparam wide_t ZERO = '0;
  localparam wide_t ONE  = wide_t'(1) << FRAC;
  localparam wide_t HALF = wide_t'(1) << (FRAC - 1);
  localparam wide_t TWO  = wide_t'(1) << (FRAC + 1);
  localparam wide_t B1   = wide_t'(7) << (FRAC - 1);
  localparam wide_t B2   = wide_t'(3) << (FRAC - 1);
  localparam wide_t C25  = wide_t'(25) << (FRAC - 5);
  localparam wide_t C7   = wide_t'(7) << (FRAC - 5);
  localparam wide_t C12  = wide_t'(12) << (FRAC - 5);
  localparam wide_t MAXV = {{(WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam wide_t MINV = {{(WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

  // Segment codes decoded in S1; HI/LO are the flat segments of modes 1-3.
  localparam logic [2:0] SEG_LIN = 3'd0;
  localparam logic [2:0] SEG_HI  = 3'd1;
  localparam logic [2:0] SEG_LO  = 3'd2;
  localparam logic [2:0] SEG_UP  = 3'd3;
  localparam logic [2:0] SEG_DN  = 3'd4;
  localparam logic [2:0] SEG_POS = 3'd5;
  localparam logic [2:0] SEG_NEG = 3'd6;

  function automatic wide_t sext(input logic [WIDTH-1:0] v);
    return {{WIDTH{v[WIDTH-1]}}, v};
  endfunction

  logic                   v1, v2;
  logic                   s1_adv, s2_adv;
  logic [LANES*WIDTH-1:0] x1;
  logic [1:0]             mode1;
  logic [2:0]             seg1   [LANES];
  wide_t                  prod1  [LANES];
  logic [2:0]             seg_c  [LANES];
  wide_t                  prod_c [LANES];
  logic [LANES*WIDTH-1:0] res_c;

  assign s2_adv    = !v2 || out_ready;
  assign s1_adv    = !v1 || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = v2;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      wide_t xw;
      xw        = sext(in_data[i*WIDTH +: WIDTH]);
      prod_c[i] = sext(in_alpha) * xw;
      seg_c[i]  = SEG_LIN;
      case (in_mode)
        2'd0: seg_c[i] = (xw > ZERO) ? SEG_POS : SEG_NEG;
        2'd1: begin
          if (xw > TWO)        seg_c[i] = SEG_HI;
          else if (xw < -TWO)  seg_c[i] = SEG_LO;
        end
        2'd2: begin
          if (xw >= B1)        seg_c[i] = SEG_HI;
          else if (xw <= -B1)  seg_c[i] = SEG_LO;
          else if (xw > B2)    seg_c[i] = SEG_UP;
          else if (xw < -B2)   seg_c[i] = SEG_DN;
        end
        default: begin
          if (xw >= B2)        seg_c[i] = SEG_HI;
          else if (xw <= -B2)  seg_c[i] = SEG_LO;
          else if (xw > HALF)  seg_c[i] = SEG_UP;
          else if (xw < -HALF) seg_c[i] = SEG_DN;
        end
      endcase
    end
  end

`ifdef ACT_SAT_COUNT_EN
  logic [LANES-1:0] sat_c;
  logic [LANES-1:0] sat2;
  logic [31:0]      sat_add;
`endif

  always_comb begin
    res_c = '0;
`ifdef ACT_SAT_COUNT_EN
    sat_c = '0;
`endif
    for (int i = 0; i < LANES; i++) begin
      wide_t xw;
      wide_t w;
      xw = sext(x1[i*WIDTH +: WIDTH]);
      w  = xw;
      case (mode1)
        2'd0: w = (seg1[i] == SEG_POS) ? xw : (prod1[i] >>> FRAC);
        2'd1: begin
          case (seg1[i])
            SEG_HI:  w = ONE;
            SEG_LO:  w = ZERO;
            default: w = ((xw >>> 1) + ONE) >>> 1;
          endcase
        end
        2'd2: begin
          case (seg1[i])
            SEG_HI:  w = ONE;
            SEG_LO:  w = ZERO;
            SEG_UP:  w = (xw >>> 4) + C25;
            SEG_DN:  w = (xw >>> 4) + C7;
            default: w = (xw >>> 2) + HALF;
          endcase
        end
        default: begin
          case (seg1[i])
            SEG_HI:  w = ONE;
            SEG_LO:  w = -ONE;
            SEG_UP:  w = (xw >>> 2) + C12;
            SEG_DN:  w = (xw >>> 2) - C12;
            default: w = xw;
          endcase
        end
      endcase
      if (w > MAXV)      res_c[i*WIDTH +: WIDTH] = MAXV[WIDTH-1:0];
      else if (w < MINV) res_c[i*WIDTH +: WIDTH] = MINV[WIDTH-1:0];
      else               res_c[i*WIDTH +: WIDTH] = w[WIDTH-1:0];
`ifdef ACT_SAT_COUNT_EN
      sat_c[i] = ((mode1 != 2'd0) && (seg1[i] == SEG_HI || seg1[i] == SEG_LO))
                 || (w > MAXV) || (w < MINV);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      out_data <= '0;
    end else begin
      if (s1_adv) begin
        v1 <= in_valid;
        if (in_valid) begin
          x1    <= in_data;
          mode1 <= in_mode;
          seg1  <= seg_c;
          prod1 <= prod_c;
        end
      end
      if (s2_adv) begin
        v2 <= v1;
        if (v1) out_data <= res_c;
      end
    end
  end

`ifdef ACT_SAT_COUNT_EN
  // Flags ride with the S2 beat so a stalled beat is counted only at its handshake.
  always_comb begin
    sat_add = '0;
    for (int i = 0; i < LANES; i++) sat_add = sat_add + 32'(sat2[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat2      <= '0;
      sat_count <= '0;
    end else begin
      if (s2_adv && v1) sat2 <= sat_c;
      if (v2 && out_ready) sat_count <= sat_count + sat_add;
    end
  end
`endif

endmodule

// File: tb/tb_act_stream_unit.sv
// Directed bench for act_stream_unit at default parameters (WIDTH=16, FRAC=8, LANES=4).
module tb_act_stream_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_mode;
  logic [15:0] in_alpha;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
`ifdef ACT_SAT_COUNT_EN
  logic [31:0] sat_count;
`endif

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  act_stream_unit dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_alpha(in_alpha), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef ACT_SAT_COUNT_EN
    , .sat_count(sat_count)
`endif
  );

  function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one beat with out_ready high; reports in_ready at offer and out_valid one, two and three cycles later.
  task automatic send_single(input logic [1:0] m, input logic [15:0] a, input logic [63:0] d,
                             output logic rdy, output logic v1o, output logic v2o,
                             output logic [63:0] dout, output logic v3o);
    in_mode = m; in_alpha = a; in_data = d; in_valid = 1'b1; out_ready = 1'b1;
    #1 rdy = in_ready;
    step();
    in_valid = 1'b0; in_data = '0;
    v1o = out_valid;
    step();
    v2o = out_valid; dout = out_data;
    step();
    v3o = out_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_mode = 2'd0; in_alpha = '0; in_data = '0;
    repeat (3) step();
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    vectors++; if (out_data !== 64'd0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
`ifdef ACT_SAT_COUNT_EN
    vectors++; if (sat_count !== 32'd0) begin errors++; $display("FAIL reset_sat_count: got %0d expected 0", sat_count); end
`endif
    rst = 1'b0;
    step();
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_lrelu();
    logic [15:0] a [3];
    logic [63:0] d [3], e [3];
    logic r, v1o, v2o, v3o;
    logic [63:0] got;
    a = '{16'd26, 16'h7FFF, 16'h8000};
    d = '{pk(-256, 256, 0, -32768), pk(-32768, 0, 1, -1), pk(-32768, -1, 2, 3)};
    e = '{pk(-26, 256, 0, -3328),   pk(-32768, 0, 1, -128), pk(32767, 128, 2, 3)};
    for (int i = 0; i < 3; i++) begin
      send_single(2'd0, a[i], d[i], r, v1o, v2o, got, v3o);
      vectors++; if ({r, v1o, v2o, v3o} !== 4'b1010) begin errors++; $display("FAIL lrelu_timing[%0d]: got %b expected 1010", i, {r, v1o, v2o, v3o}); end
      vectors++; if (got !== e[i]) begin errors++; $display("FAIL lrelu_data[%0d]: got %h expected %h", i, got, e[i]); end
    end
  endtask

  task automatic test_sig3();
    logic [63:0] d [2], e [2];
    logic r, v1o, v2o, v3o;
    logic [63:0] got;
    d = '{pk(0, 256, 600, -600),  pk(512, -512, -32768, 32767)};
    e = '{pk(128, 192, 256, 0),   pk(256, 0, 0, 256)};
    for (int i = 0; i < 2; i++) begin
      send_single(2'd1, 16'd0, d[i], r, v1o, v2o, got, v3o);
      vectors++; if ({r, v1o, v2o, v3o} !== 4'b1010) begin errors++; $display("FAIL sig3_timing[%0d]: got %b expected 1010", i, {r, v1o, v2o, v3o}); end
      vectors++; if (got !== e[i]) begin errors++; $display("FAIL sig3_data[%0d]: got %h expected %h", i, got, e[i]); end
    end
  endtask

  task automatic test_sig5();
    logic [63:0] d [3], e [3];
    logic r, v1o, v2o, v3o;
    logic [63:0] got;
    d = '{pk(256, 640, -640, 896), pk(384, -384, -896, 0), pk(897, -1, -897, -32768)};
    e = '{pk(192, 240, 16, 256),   pk(224, 32, 0, 128),    pk(256, 127, 0, 0)};
    for (int i = 0; i < 3; i++) begin
      send_single(2'd2, 16'd0, d[i], r, v1o, v2o, got, v3o);
      vectors++; if ({r, v1o, v2o, v3o} !== 4'b1010) begin errors++; $display("FAIL sig5_timing[%0d]: got %b expected 1010", i, {r, v1o, v2o, v3o}); end
      vectors++; if (got !== e[i]) begin errors++; $display("FAIL sig5_data[%0d]: got %h expected %h", i, got, e[i]); end
    end
  endtask

  task automatic test_tanh();
    logic [63:0] d [3], e [3];
    logic r, v1o, v2o, v3o;
    logic [63:0] got;
    d = '{pk(64, 256, 400, -256), pk(128, -128, 384, -384), pk(129, -129, -32768, 1)};
    e = '{pk(64, 160, 256, -160), pk(128, -128, 256, -256), pk(128, -129, -256, 1)};
    for (int i = 0; i < 3; i++) begin
      send_single(2'd3, 16'd0, d[i], r, v1o, v2o, got, v3o);
      vectors++; if ({r, v1o, v2o, v3o} !== 4'b1010) begin errors++; $display("FAIL tanh_timing[%0d]: got %b expected 1010", i, {r, v1o, v2o, v3o}); end
      vectors++; if (got !== e[i]) begin errors++; $display("FAIL tanh_data[%0d]: got %h expected %h", i, got, e[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [1:0]  bm [10];
    logic [15:0] ba [10];
    logic [63:0] bd [10], be [10];
    int prod = 0;
    int cons = 0;
    int blocked = 0;
    int extra = 0;
    logic stalled = 1'b0;
    logic [63:0] held = '0;
    bm = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3};
    ba = '{16'd26, 16'd0, 16'd0, 16'd0, 16'd128, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    bd = '{pk(-256, 256, 0, -32768), pk(0, 256, 600, -600), pk(256, 640, -640, 896),
           pk(64, 256, 400, -256),   pk(-512, 100, -1, 1),  pk(512, -512, -32768, 32767),
           pk(384, -384, -896, 0),   pk(128, -128, 384, -384), pk(897, -1, -897, -32768),
           pk(129, -129, -32768, 1)};
    be = '{pk(-26, 256, 0, -3328),   pk(128, 192, 256, 0),  pk(192, 240, 16, 256),
           pk(64, 160, 256, -160),   pk(-256, 100, -1, 1),  pk(256, 0, 0, 256),
           pk(224, 32, 0, 128),      pk(128, -128, 256, -256), pk(256, 127, 0, 0),
           pk(128, -129, -256, 1)};
    for (int cyc = 0; cyc < 120 && cons < 10; cyc++) begin
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      if (prod < 10) begin
        in_valid = 1'b1; in_mode = bm[prod]; in_alpha = ba[prod]; in_data = bd[prod];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stalled) begin
        vectors++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          errors++; $display("FAIL bp_hold[%0d]: got v=%b d=%h expected v=1 d=%h", cyc, out_valid, out_data, held);
        end
      end
      if (!in_ready) blocked++;
      if (out_valid && out_ready) begin
        vectors++;
        if (out_data !== be[cons]) begin errors++; $display("FAIL bp_data[%0d]: got %h expected %h", cons, out_data, be[cons]); end
        cons++;
      end
      stalled = out_valid && !out_ready;
      held    = out_data;
      if (in_valid && in_ready) prod++;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    vectors++; if (cons != 10) begin errors++; $display("FAIL bp_count: got %0d beats expected 10", cons); end
    vectors++; if (blocked == 0) begin errors++; $display("FAIL bp_in_ready_low: got %0d blocked cycles expected >0", blocked); end
    for (int k = 0; k < 4; k++) begin
      #1;
      if (out_valid) extra++;
      step();
    end
    vectors++; if (extra != 0) begin errors++; $display("FAIL bp_extra_beats: got %0d expected 0", extra); end
  endtask

  task automatic test_mid_reset();
    int stale = 0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 2'd3; in_alpha = '0; in_data = pk(64, 256, 400, -256);
    step();
    in_data = pk(600, 600, 600, 600); in_mode = 2'd1;
    step();
    in_valid = 1'b0;
    #1;
    vectors++; if ({out_valid, in_ready} !== 2'b10) begin errors++; $display("FAIL mrst_full: got v/rdy=%b expected 10", {out_valid, in_ready}); end
    rst = 1'b1;
    step();
    vectors++; if (out_valid !== 1'b0 || out_data !== 64'd0) begin errors++; $display("FAIL mrst_clear: got v=%b d=%h expected v=0 d=0", out_valid, out_data); end
`ifdef ACT_SAT_COUNT_EN
    vectors++; if (sat_count !== 32'd0) begin errors++; $display("FAIL mrst_sat: got %0d expected 0", sat_count); end
`endif
    rst = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      if (out_valid !== 1'b0) stale++;
    end
    vectors++; if (stale != 0 || in_ready !== 1'b1) begin errors++; $display("FAIL mrst_stale: got %0d stale rdy=%b expected 0 stale rdy=1", stale, in_ready); end
  endtask

`ifdef ACT_SAT_COUNT_EN
  task automatic test_sat_count();
    logic r, v1o, v2o, v3o;
    logic [63:0] got;
    rst = 1'b1; step(); rst = 1'b0; step();
    send_single(2'd1, 16'd0, pk(600, -600, 600, -600), r, v1o, v2o, got, v3o);
    vectors++; if (sat_count !== 32'd4) begin errors++; $display("FAIL sat_beat1: got %0d expected 4", sat_count); end
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'd1; in_data = pk(-600, 600, -600, 600);
    step();
    in_valid = 1'b0;
    repeat (5) step();
    vectors++; if (sat_count !== 32'd4 || out_valid !== 1'b1) begin errors++; $display("FAIL sat_stalled: got %0d v=%b expected 4 v=1", sat_count, out_valid); end
    out_ready = 1'b1; step(); out_ready = 1'b0; repeat (2) step();
    vectors++; if (sat_count !== 32'd8) begin errors++; $display("FAIL sat_once: got %0d expected 8", sat_count); end
    send_single(2'd1, 16'd0, pk(600, 600, -600, -600), r, v1o, v2o, got, v3o);
    vectors++; if (sat_count !== 32'd12) begin errors++; $display("FAIL sat_beat3: got %0d expected 12", sat_count); end
    send_single(2'd0, 16'h7FFF, pk(-32768, 1, 2, 3), r, v1o, v2o, got, v3o);
    vectors++; if (sat_count !== 32'd13) begin errors++; $display("FAIL sat_lrelu: got %0d expected 13", sat_count); end
    send_single(2'd1, 16'd0, pk(512, -512, 0, 1), r, v1o, v2o, got, v3o);
    vectors++; if (sat_count !== 32'd13) begin errors++; $display("FAIL sat_edge: got %0d expected 13", sat_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_lrelu();
    test_sig3();
    test_sig5();
    test_tanh();
    test_backpressure();
    test_mid_reset();
`ifdef ACT_SAT_COUNT_EN
    test_sat_count();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
